// File: rtl/raster_fb_writer_if.sv
// Pixel-in / flush / framebuffer write-request bundle for raster_fb_writer.
// master = pixel source and memory side, slave = the writer itself.
interface raster_fb_writer_if;
   logic [7:0]  in_data;
   logic [10:0] pixel_x;
   logic [10:0] pixel_y;
   logic        draw;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        done;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_valid;
   logic        mem_ready;

   modport master (
      output in_data, pixel_x, pixel_y, draw, in_valid, flush, mem_ready,
      input  in_ready, done, mem_addr, mem_wdata, mem_wstrb, mem_valid
   );

   modport slave (
      input  in_data, pixel_x, pixel_y, draw, in_valid, flush, mem_ready,
      output in_ready, done, mem_addr, mem_wdata, mem_wstrb, mem_valid
   );
endinterface

// File: rtl/raster_fb_writer.sv
// Framebuffer write stage: filters off-screen/non-drawn pixels, coalesces bytes
// into 32-bit strobed words and issues them; flush drains everything then pulses done.
module raster_fb_writer #(
   parameter int unsigned FB_WIDTH  = 800,
   parameter int unsigned FB_HEIGHT = 600,
   parameter logic [31:0] FB_BASE   = 32'h1000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   raster_fb_writer_if.slave         fb,
   output logic [31:0]               pix_written,
   output logic [31:0]               pix_dropped
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;

   logic        r_s1_valid;
   logic [20:0] r_s1_idx;
   logic        r_s1_oob;
   logic        r_s1_draw;
   logic [7:0]  r_s1_data;

   logic        r_buf_valid;
   logic [18:0] r_buf_widx;
   logic [31:0] r_buf_data;
   logic [3:0]  r_buf_strb;

   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;

   logic [31:0] r_pix_written;
   logic [31:0] r_pix_dropped;

   logic [20:0] w_pix_idx;
   logic        w_oob;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_out_free;
   logic        w_s1_discard;
   logic [18:0] w_s1_widx;
   logic        w_same_word;
   logic        w_merge;
   logic        w_evict;
   logic        w_flush_evict;
   logic        w_load_out;
   logic        w_s1_adv;
   logic [31:0] w_byte_data;
   logic [31:0] w_byte_mask;
   logic [3:0]  w_byte_strb;
   logic [31:0] w_buf_base_data;
   logic [3:0]  w_buf_base_strb;

   assign w_pix_idx = 21'(32'(fb.pixel_y) * FB_WIDTH + 32'(fb.pixel_x));
   assign w_oob     = (32'(fb.pixel_x) >= FB_WIDTH) | (32'(fb.pixel_y) >= FB_HEIGHT);

   assign w_out_free   = !r_mem_valid | fb.mem_ready;
   assign w_s1_discard = !r_s1_draw | r_s1_oob;
   assign w_s1_widx    = r_s1_idx[20:2];
   assign w_same_word  = (r_buf_widx == w_s1_widx);

   assign w_merge       = r_s1_valid & !w_s1_discard & (!r_buf_valid | w_same_word);
   assign w_evict       = r_s1_valid & !w_s1_discard & r_buf_valid & !w_same_word & w_out_free;
   // Once S1 is empty during a flush, the last partial word is pushed out on its own.
   assign w_flush_evict = (r_state == ST_FLUSH) & !r_s1_valid & r_buf_valid & w_out_free;
   assign w_load_out    = w_evict | w_flush_evict;
   assign w_s1_adv      = r_s1_valid & (w_s1_discard | w_merge | w_evict);

   assign w_in_ready = !reset & (r_state == ST_RUN) & (!r_s1_valid | w_s1_adv);
   assign w_accept   = fb.in_valid & w_in_ready;

   assign w_byte_data     = 32'(r_s1_data) << {r_s1_idx[1:0], 3'b000};
   assign w_byte_mask     = 32'h0000_00FF << {r_s1_idx[1:0], 3'b000};
   assign w_byte_strb     = 4'b0001 << r_s1_idx[1:0];
   assign w_buf_base_data = r_buf_valid ? r_buf_data : 32'h0000_0000;
   assign w_buf_base_strb = r_buf_valid ? r_buf_strb : 4'b0000;

   // Next-state decode for the RUN -> FLUSH -> DONE -> RUN sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (fb.flush) w_state_nxt = ST_FLUSH;
            else          w_state_nxt = ST_RUN;
         end
         ST_FLUSH: begin
            if (!r_s1_valid && !r_buf_valid && !r_mem_valid) w_state_nxt = ST_DONE;
            else                                              w_state_nxt = ST_FLUSH;
         end
         ST_DONE:  w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   // S1: registered beat with its linear index and off-screen flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_idx   <= 21'd0;
         r_s1_oob   <= 1'b0;
         r_s1_draw  <= 1'b0;
         r_s1_data  <= 8'd0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_idx   <= w_pix_idx;
         r_s1_oob   <= w_oob;
         r_s1_draw  <= fb.draw;
         r_s1_data  <= fb.in_data;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= r_s1_valid;
      end
   end

   // Coalesce buffer: merges into the current word or restarts with the S1 byte on eviction.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_widx  <= 19'd0;
         r_buf_data  <= 32'd0;
         r_buf_strb  <= 4'd0;
      end else if (w_merge) begin
         r_buf_valid <= 1'b1;
         r_buf_widx  <= w_s1_widx;
         r_buf_data  <= (w_buf_base_data & ~w_byte_mask) | w_byte_data;
         r_buf_strb  <= w_buf_base_strb | w_byte_strb;
      end else if (w_evict) begin
         r_buf_valid <= 1'b1;
         r_buf_widx  <= w_s1_widx;
         r_buf_data  <= w_byte_data;
         r_buf_strb  <= w_byte_strb;
      end else if (w_flush_evict) begin
         r_buf_valid <= 1'b0;
         r_buf_data  <= 32'd0;
         r_buf_strb  <= 4'd0;
      end else begin
         r_buf_valid <= r_buf_valid;
      end
   end

   // Output request register; only reloaded when free, so it holds steady under stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_valid <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_wstrb <= 4'd0;
      end else if (w_load_out) begin
         r_mem_valid <= 1'b1;
         r_mem_addr  <= FB_BASE + {11'd0, r_buf_widx, 2'b00};
         r_mem_wdata <= r_buf_data;
         r_mem_wstrb <= r_buf_strb;
      end else if (fb.mem_ready) begin
         r_mem_valid <= 1'b0;
      end else begin
         r_mem_valid <= r_mem_valid;
      end
   end

   // Pixel statistics, wrapping silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix_written <= 32'd0;
         r_pix_dropped <= 32'd0;
      end else begin
         if (w_merge || w_evict) r_pix_written <= r_pix_written + 32'd1;
         else                    r_pix_written <= r_pix_written;
         if (r_s1_valid && r_s1_draw && r_s1_oob) r_pix_dropped <= r_pix_dropped + 32'd1;
         else                                     r_pix_dropped <= r_pix_dropped;
      end
   end

   assign fb.in_ready  = w_in_ready;
   assign fb.done      = (r_state == ST_DONE);
   assign fb.mem_valid = r_mem_valid;
   assign fb.mem_addr  = r_mem_addr;
   assign fb.mem_wdata = r_mem_wdata;
   assign fb.mem_wstrb = r_mem_wstrb;
   assign pix_written  = r_pix_written;
   assign pix_dropped  = r_pix_dropped;

endmodule

// File: tb/tb_raster_fb_writer.sv
// Directed self-checking bench for raster_fb_writer: single-beat vector table
// followed by hand-written multi-cycle sequences (coalescing, stall, reset).
module tb_raster_fb_writer;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] pix_written;
   logic [31:0] pix_dropped;

   raster_fb_writer_if fb ();

   raster_fb_writer #(
      .FB_WIDTH  (800),
      .FB_HEIGHT (600),
      .FB_BASE   (BASE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fb          (fb),
      .pix_written (pix_written),
      .pix_dropped (pix_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_done = 0;

   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [3:0]  q_strb[$];

   logic        prev_stall;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   logic [3:0]  prev_strb;

   typedef struct {
      logic [10:0] x;
      logic [10:0] y;
      logic [7:0]  d;
      logic        draw;
      int          n;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] wr;
      logic [31:0] drop;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Write-port monitor: logs accepted words and checks stability under stall.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, fb.mem_valid}, 32'd1);
            chk("stall_addr", fb.mem_addr, prev_addr);
            chk("stall_wdata", fb.mem_wdata, prev_data);
            chk("stall_wstrb", {28'd0, fb.mem_wstrb}, {28'd0, prev_strb});
         end
         if (fb.mem_valid && fb.mem_ready) begin
            q_addr.push_back(fb.mem_addr);
            q_data.push_back(fb.mem_wdata);
            q_strb.push_back(fb.mem_wstrb);
            chk("wstrb_nonzero", {31'd0, (fb.mem_wstrb != 4'd0)}, 32'd1);
         end
         if (fb.done) n_done++;
         prev_stall <= fb.mem_valid && !fb.mem_ready;
         prev_addr  <= fb.mem_addr;
         prev_data  <= fb.mem_wdata;
         prev_strb  <= fb.mem_wstrb;
      end
   end

   task automatic clear_q();
      q_addr.delete();
      q_data.delete();
      q_strb.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send_beat(input logic [10:0] x, input logic [10:0] y,
                            input logic [7:0] d, input logic dr);
      logic ok;
      bit   got;
      got = 1'b0;
      fb.pixel_x  = x;
      fb.pixel_y  = y;
      fb.in_data  = d;
      fb.draw     = dr;
      fb.in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         ok = fb.in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            got = 1'b1;
            break;
         end
      end
      fb.in_valid = 1'b0;
      if (!got) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_flush();
      fb.flush = 1'b1;
      @(posedge clk);
      #1;
      fb.flush = 1'b0;
   endtask

   task automatic wait_done(output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         n++;
         if (fb.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_q();
   endtask

   task automatic chk_word(input string nm, input int i, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      if (q_addr.size() > i) begin
         chk({nm, "_addr"}, q_addr[i], a);
         chk({nm, "_wdata"}, q_data[i], d);
         chk({nm, "_wstrb"}, {28'd0, q_strb[i]}, {28'd0, s});
      end else begin
         chk({nm, "_missing"}, 32'(q_addr.size()), 32'(i + 1));
      end
   endtask

   initial begin
      int n;
      int done_snap;

      vt[0] = '{11'd0,    11'd0,    8'h11, 1'b1, 1, BASE,                 32'h0000_0011, 4'h1, 32'd1, 32'd0};
      vt[1] = '{11'd3,    11'd0,    8'hC3, 1'b1, 1, BASE,                 32'hC300_0000, 4'h8, 32'd2, 32'd0};
      vt[2] = '{11'd799,  11'd599,  8'h7E, 1'b1, 1, BASE + 32'h0007_52FC, 32'h7E00_0000, 4'h8, 32'd3, 32'd0};
      vt[3] = '{11'd800,  11'd0,    8'h01, 1'b1, 0, 32'd0,                32'd0,         4'h0, 32'd3, 32'd1};
      vt[4] = '{11'd0,    11'd600,  8'h02, 1'b1, 0, 32'd0,                32'd0,         4'h0, 32'd3, 32'd2};
      vt[5] = '{11'd2047, 11'd2047, 8'h03, 1'b1, 0, 32'd0,                32'd0,         4'h0, 32'd3, 32'd3};
      vt[6] = '{11'd5,    11'd5,    8'h04, 1'b0, 0, 32'd0,                32'd0,         4'h0, 32'd3, 32'd3};
      vt[7] = '{11'd1,    11'd1,    8'h5A, 1'b1, 1, BASE + 32'd800,       32'h0000_5A00, 4'h2, 32'd4, 32'd3};
      vt[8] = '{11'd2,    11'd2,    8'h9C, 1'b1, 1, BASE + 32'd1600,      32'h009C_0000, 4'h4, 32'd5, 32'd3};
      vt[9] = '{11'd0,    11'd599,  8'h05, 1'b0, 0, 32'd0,                32'd0,         4'h0, 32'd5, 32'd3};

      reset        = 1'b1;
      fb.in_data   = 8'd0;
      fb.pixel_x   = 11'd0;
      fb.pixel_y   = 11'd0;
      fb.draw      = 1'b0;
      fb.in_valid  = 1'b0;
      fb.flush     = 1'b0;
      fb.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, fb.in_ready}, 32'd0);
      chk("rst_done", {31'd0, fb.done}, 32'd0);
      chk("rst_mem_valid", {31'd0, fb.mem_valid}, 32'd0);
      chk("rst_mem_addr", fb.mem_addr, 32'd0);
      chk("rst_pix_written", pix_written, 32'd0);
      chk("rst_pix_dropped", pix_dropped, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, fb.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         clear_q();
         send_beat(vt[i].x, vt[i].y, vt[i].d, vt[i].draw);
         do_flush();
         wait_done(n);
         chk($sformatf("vec%0d_nwrites", i), 32'(q_addr.size()), 32'(vt[i].n));
         if (vt[i].n > 0) chk_word($sformatf("vec%0d", i), 0, vt[i].addr, vt[i].wdata, vt[i].strb);
         chk($sformatf("vec%0d_written", i), pix_written, vt[i].wr);
         chk($sformatf("vec%0d_dropped", i), pix_dropped, vt[i].drop);
      end

      // Four bytes coalesced into one full word.
      do_reset();
      for (int x = 0; x < 4; x++) send_beat(11'(x), 11'd0, 8'(8'h11 * (x + 1)), 1'b1);
      do_flush();
      wait_done(n);
      chk("full_nwrites", 32'(q_addr.size()), 32'd1);
      chk_word("full", 0, BASE, 32'h4433_2211, 4'hF);
      chk("full_written", pix_written, 32'd4);

      // Off-screen and non-drawn beats filtered out.
      do_reset();
      send_beat(11'd5, 11'd0, 8'hAA, 1'b1);
      send_beat(11'd800, 11'd0, 8'hBB, 1'b1);
      send_beat(11'd0, 11'd600, 8'hCC, 1'b1);
      send_beat(11'd9, 11'd0, 8'hDD, 1'b0);
      do_flush();
      wait_done(n);
      chk("filt_nwrites", 32'(q_addr.size()), 32'd1);
      chk_word("filt", 0, BASE + 32'd4, 32'h0000_AA00, 4'h2);
      chk("filt_dropped", pix_dropped, 32'd2);
      chk("filt_written", pix_written, 32'd1);

      // Downstream stall: first word held, input backpressured, then released.
      do_reset();
      fb.mem_ready = 1'b0;
      fork
         begin
            for (int x = 0; x < 9; x++) send_beat(11'(x), 11'd1, 8'(x + 1), 1'b1);
         end
         begin
            repeat (15) @(negedge clk);
            chk("stall_in_ready", {31'd0, fb.in_ready}, 32'd0);
            chk("stall_mem_valid", {31'd0, fb.mem_valid}, 32'd1);
            chk("stall_first_addr", fb.mem_addr, BASE + 32'd800);
            repeat (5) @(posedge clk);
            #1;
            fb.mem_ready = 1'b1;
         end
      join
      do_flush();
      wait_done(n);
      chk("stall_nwrites", 32'(q_addr.size()), 32'd3);
      chk_word("stall_w0", 0, BASE + 32'd800, 32'h0403_0201, 4'hF);
      chk_word("stall_w1", 1, BASE + 32'd804, 32'h0807_0605, 4'hF);
      chk_word("stall_w2", 2, BASE + 32'd808, 32'h0000_0009, 4'h1);
      chk("stall_written", pix_written, 32'd9);

      // Same byte written twice: later value wins.
      do_reset();
      send_beat(11'd2, 11'd3, 8'h55, 1'b1);
      send_beat(11'd2, 11'd3, 8'h66, 1'b1);
      do_flush();
      wait_done(n);
      chk("dup_nwrites", 32'(q_addr.size()), 32'd1);
      chk_word("dup", 0, BASE + 32'd2400, 32'h0066_0000, 4'h4);

      // Empty flush: done two cycles later, no write.
      clear_q();
      do_flush();
      wait_done(n);
      chk("empty_done_latency", 32'(n), 32'd2);
      chk("empty_nwrites", 32'(q_addr.size()), 32'd0);

      // Reset while a write is stalled downstream.
      do_reset();
      fb.mem_ready = 1'b0;
      for (int x = 0; x < 5; x++) send_beat(11'(x), 11'd0, 8'(x + 1), 1'b1);
      for (int k = 0; k < 20; k++) begin
         if (fb.mem_valid) break;
         @(posedge clk);
         #1;
      end
      chk("rmid_pre_valid", {31'd0, fb.mem_valid}, 32'd1);
      done_snap = n_done;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rmid_mem_valid", {31'd0, fb.mem_valid}, 32'd0);
      chk("rmid_written", pix_written, 32'd0);
      chk("rmid_dropped", pix_dropped, 32'd0);
      @(posedge clk);
      #1;
      clear_q();
      fb.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rmid_no_done", 32'(n_done), 32'(done_snap));
      do_flush();
      wait_done(n);
      chk("rmid_flush_latency", 32'(n), 32'd2);
      chk("rmid_nwrites", 32'(q_addr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
